// File: rtl/regbank_access_ctrl_pkg.sv
// Shared definitions for the 4 x 8-bit register bank and its access controller.
package regbank_access_ctrl_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Request opcodes as carried on req_op.
  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_MOVE  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    MV_RD = 3'd3,
    MV_WR = 3'd4,
    CLR   = 3'd5,
    RESP  = 3'd6
  } state_e;

endpackage

// File: rtl/regbank_access_ctrl.sv
// Initiator for the register bank: accepts one operation at a time over a
// valid/ready request channel, sequences the bank control lines from
// registered state only, and returns the result over a valid/ready channel.
module regbank_access_ctrl
  import regbank_access_ctrl_pkg::*;
#(
  parameter int DATA_W = regbank_access_ctrl_pkg::DATA_W,
  parameter int ADDR_W = regbank_access_ctrl_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [ADDR_W-1:0] req_src,
  input  logic [DATA_W-1:0] req_imm,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_write,
  output logic              rf_rst,
  input  logic [DATA_W-1:0] rf_out
);

  localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_data_q;
  logic [DATA_W-1:0] resp_data_q;

  // Next-state decode; every op runs a fixed number of cycles, then waits in RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          case (op_e'(req_op))
            OP_WRITE: state_d = WR;
            OP_READ:  state_d = RD;
            OP_MOVE:  state_d = MV_RD;
            default:  state_d = CLR;
          endcase
        end
      end
      WR:      state_d = RESP;
      RD:      state_d = RESP;
      MV_RD:   state_d = MV_WR;
      MV_WR:   state_d = RESP;
      CLR:     if (cnt_q == '1) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand, bank-drive and result registers. The bank address/data
  // are registered so they hold their last value in IDLE and never follow req_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dst_q       <= '0;
      cnt_q       <= '0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            dst_q     <= req_dst;
            rf_data_q <= req_imm;
            cnt_q     <= '0;
            case (op_e'(req_op))
              OP_MOVE:  rf_addr_q <= req_src;
              OP_CLEAR: rf_addr_q <= '0;
              default:  rf_addr_q <= req_dst;
            endcase
          end
        end
        WR:    resp_data_q <= rf_data_q;
        RD:    resp_data_q <= rf_out;
        MV_RD: begin
          rf_addr_q <= dst_q;
          rf_data_q <= rf_out;
        end
        MV_WR: resp_data_q <= rf_data_q;
        CLR: begin
          if (cnt_q != '1) begin
            cnt_q     <= cnt_q + CNT_ONE;
            rf_addr_q <= cnt_q + CNT_ONE;
          end else begin
            cnt_q       <= '0;
            resp_data_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs: strobes and handshakes decode from the state register only.
  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign rf_addr    = rf_addr_q;
  assign rf_data    = rf_data_q;
  assign rf_write   = (state_q == WR) || (state_q == MV_WR);
  assign rf_rst     = (state_q == CLR);

endmodule

// File: doc/regbank_access_ctrl.md
Name: regbank_access_ctrl

Overview:
- Initiator side of the 4 x 8-bit register bank interface (addr/data/write/rst in, out back).
- Accepts register operations over a valid/ready request channel and sequences the bank's control lines: WRITE, READ, MOVE, CLEAR_ALL.
- Returns a result over a valid/ready response channel.
- Sits between the instruction decode stage and the register bank; it is the only driver of the bank's control inputs.

Parameters:
DATA_W, 8, register width; must match the bank.
ADDR_W, 2, register address width; NUM_REGS = 2**ADDR_W = 4.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset of this block only; never drives bank rst
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_op  input  2  00 WRITE, 01 READ, 10 MOVE, 11 CLEAR_ALL
req_dst  input  ADDR_W  destination/read address
req_src  input  ADDR_W  MOVE source address
req_imm  input  DATA_W  WRITE immediate
resp_valid  output  1  result present
resp_ready  input  1  consumer accepts result
resp_data  output  DATA_W  result value
busy  output  1  high in any state other than IDLE
rf_addr  output  ADDR_W  bank address
rf_data  output  DATA_W  bank write data
rf_write  output  1  bank write strobe
rf_rst  output  1  bank per-address clear strobe
rf_out  input  DATA_W  bank read data

Behaviour:
- Reset: state=IDLE. All outputs 0 except req_ready=1. Operand and counter registers 0.
- Reset mid-operation: abandon the operation at the next edge. rf_write and rf_rst drop to 0. A pending response is discarded.
- All rf_* outputs and resp_* outputs decode from registered state/operands only (Moore); no combinational path from req_* to rf_*.
- rf_write and rf_rst are never both 1. Outside WR, MV_WR and CLR both are 0, which puts the bank in read mode.
- IDLE: req_ready=1. On req_valid&&req_ready, latch op/dst/src/imm and move to that op's first state. Otherwise rf_addr and rf_data hold their last values.
- WR (1 cycle): rf_addr=dst, rf_data=imm, rf_write=1. Next state RESP, resp_data<=imm.
- RD (1 cycle): rf_addr=dst, strobes 0. At the exit edge, capture rf_out into resp_data. Next state RESP.
- MV_RD (1 cycle): rf_addr=src, strobes 0. Capture rf_out into the move register.
- MV_WR (1 cycle): rf_addr=dst, rf_data=move register, rf_write=1. Next state RESP, resp_data=moved value.
- MOVE with src==dst is legal: it rewrites the same value and takes the same 2 cycles.
- CLR (4 cycles): a 2-bit counter cnt runs 0..3. rf_addr=cnt, rf_rst=1.
  - cnt==3 with wrap-around to 0 moves to RESP, resp_data=0.
- RESP: resp_valid=1, resp_data stable until resp_ready. On resp_valid&&resp_ready go to IDLE.
  - The next request can be accepted no earlier than the cycle after the handshake.
- Latency, accept edge to resp_valid high: WRITE 2 cycles, READ 2, MOVE 3, CLEAR_ALL 5.
- Back-to-back throughput: one op per (latency + 1) cycles when resp_ready is held high.
- Backpressure: resp_ready low holds RESP indefinitely. Nothing is re-driven to the bank while stalled.
- req_* fields are don't-care when req_valid=0 or req_ready=0.

Decomposition:
- Shared package: op encodings (OP_WRITE, OP_READ, OP_MOVE, OP_CLEAR), the state enum (IDLE, WR, RD, MV_RD, MV_WR, CLR, RESP), DATA_W and ADDR_W constants.
- The bank and this controller both import the package.
- No sub-module; the CLR counter stays inline.

Test Plan:
- Reset, then WRITE dst=2 imm=8'hA5 -> one cycle with rf_addr=2, rf_data=A5, rf_write=1; resp_data=A5 two cycles after accept.
- WRITE r1=8'h3C, then READ dst=1 -> resp_data=3C; rf_write=0 and rf_rst=0 throughout the READ.
- WRITE r0=8'h7E, then MOVE src=0 dst=3, then READ 3 -> MOVE resp=7E; READ resp=7E; r0 unchanged at 7E.
- Fill r0..r3 with 11/22/33/44, then CLEAR_ALL -> rf_rst=1 for exactly 4 cycles with rf_addr 0,1,2,3; READs of all registers return 00; resp_data=00.
- READ with resp_ready held low for 5 cycles -> resp_valid and resp_data stable, req_ready=0; a req_valid pulse during the stall is not accepted.
- Assert rst during CLR at cnt=1 -> next edge: rf_rst=0, state IDLE, resp_valid=0, req_ready=1; r2 and r3 are not cleared.
